// File: rtl/pot_scan_sched.sv
// ---------------------------------------------------------------------------
// pot_scan_sched
//
// Round-robin scheduler that walks the six slide pots through an A2D SPI
// master. Each slot issues a one-clock strt_cnv on its channel, waits for
// cnv_cmplt (bounded by TIMEOUT clocks), captures the result into that pot's
// register, then idles GAP_CYCLES clocks before moving to the next slot.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   cnv_cmplt   conversion finished strobe from the SPI master
//   res         12-bit conversion result, valid while cnv_cmplt is high
//   strt_cnv    one-clock start request to the SPI master
//   chnnl       A2D channel, held from strt_cnv until the next strt_cnv
//   POT_LP .. VOLUME   latest result for each slide pot
//   sweep_done  one-clock pulse when slot 5 leaves WAIT
//   tmo_err     sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module pot_scan_sched #(
    parameter int GAP_CYCLES = 1024,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOLUME,
    output logic        sweep_done,
    output logic        tmo_err
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } state_t;

    // Terminal counts: a dwell of N clocks ends on the edge where the
    // counter (cleared on entry) reads N-1.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    state_t      state;
    logic [2:0]  slot;
    logic [15:0] wait_cnt;
    logic [15:0] gap_cnt;
    logic [2:0]  next_slot;

    // Slot to A2D channel mapping, fixed by the board wiring.
    function automatic logic [2:0] chnnl_of(input logic [2:0] s);
        case (s)
            3'd0:    chnnl_of = 3'd1;
            3'd1:    chnnl_of = 3'd0;
            3'd2:    chnnl_of = 3'd4;
            3'd3:    chnnl_of = 3'd2;
            3'd4:    chnnl_of = 3'd3;
            3'd5:    chnnl_of = 3'd7;
            default: chnnl_of = 3'd1;
        endcase
    endfunction

    assign next_slot = (slot == 3'd5) ? 3'd0 : 3'(slot + 3'd1);

    // Single sequencer: state, counters, strobes and all result registers.
    // strt_cnv is registered so it is high exactly while in START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot       <= 3'd0;
            chnnl      <= 3'd1;
            strt_cnv   <= 1'b0;
            wait_cnt   <= 16'd0;
            gap_cnt    <= 16'd0;
            POT_LP     <= 12'h000;
            POT_B1     <= 12'h000;
            POT_B2     <= 12'h000;
            POT_B3     <= 12'h000;
            POT_HP     <= 12'h000;
            VOLUME     <= 12'h000;
            sweep_done <= 1'b0;
            tmo_err    <= 1'b0;
        end else begin
            strt_cnv   <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= START;
                    strt_cnv <= 1'b1;
                    chnnl    <= chnnl_of(slot);
                end
                START: begin
                    state    <= WAIT;
                    wait_cnt <= 16'd0;
                end
                WAIT: begin
                    // Completion wins over a timeout expiring on the same edge.
                    if (cnv_cmplt) begin
                        case (slot)
                            3'd0:    POT_LP <= res;
                            3'd1:    POT_B1 <= res;
                            3'd2:    POT_B2 <= res;
                            3'd3:    POT_B3 <= res;
                            3'd4:    POT_HP <= res;
                            3'd5:    VOLUME <= res;
                            default: ;
                        endcase
                        state      <= GAP;
                        gap_cnt    <= 16'd0;
                        sweep_done <= (slot == 3'd5);
                    end else if (wait_cnt >= WAIT_LAST) begin
                        tmo_err    <= 1'b1;
                        state      <= GAP;
                        gap_cnt    <= 16'd0;
                        sweep_done <= (slot == 3'd5);
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        state    <= START;
                        slot     <= next_slot;
                        chnnl    <= chnnl_of(next_slot);
                        strt_cnv <= 1'b1;
                    end else if (gap_cnt != CNT_MAX) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pot_scan_sched.sv
// ---------------------------------------------------------------------------
// tb_pot_scan_sched
//
// Directed bench for pot_scan_sched at default parameters. A behavioural SPI
// master answers each strt_cnv after a chosen delay with a chosen result, or
// not at all, and the bench checks channel order, strt_cnv spacing, result
// capture, timeout handling, sweep_done and asynchronous reset recovery.
// ---------------------------------------------------------------------------
module tb_pot_scan_sched;

    logic        clk;
    logic        rst_n;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [11:0] POT_LP;
    logic [11:0] POT_B1;
    logic [11:0] POT_B2;
    logic [11:0] POT_B3;
    logic [11:0] POT_HP;
    logic [11:0] VOLUME;
    logic        sweep_done;
    logic        tmo_err;

    int test_count;
    int fail_count;
    int sweep_count;

    // Expected channel per slot, independent of the design's table.
    logic [2:0] exp_ch [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    // Normal period: 1 START + 50 WAIT + 1024 GAP.
    localparam int PERIOD_NORM = 1075;
    // Timed-out or last-clock completion: 1 START + 4096 WAIT + 1024 GAP.
    localparam int PERIOD_TMO  = 5121;

    pot_scan_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnv_cmplt  (cnv_cmplt),
        .res        (res),
        .strt_cnv   (strt_cnv),
        .chnnl      (chnnl),
        .POT_LP     (POT_LP),
        .POT_B1     (POT_B1),
        .POT_B2     (POT_B2),
        .POT_B3     (POT_B3),
        .POT_HP     (POT_HP),
        .VOLUME     (VOLUME),
        .sweep_done (sweep_done),
        .tmo_err    (tmo_err)
    );

    // 50 MHz clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count sweep_done pulses on the falling edge, mid-pulse.
    initial sweep_count = 0;
    always @(negedge clk) begin
        if (sweep_done) sweep_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Step clocks (sampling 1 ns after each rising edge) until strt_cnv is
    // seen, adding the number of edges to cyc. Gives up after a budget.
    task automatic waitStrt(inout int cyc);
        int budget;
        budget = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            budget++;
        end while (!strt_cnv && budget < 10000);
        if (!strt_cnv) checkOutput("strt_cnv_timeout", 32'(strt_cnv), 32'd1);
    endtask

    // Called 1 ns after the edge that raised strt_cnv. Checks the channel,
    // optionally returns cnv_cmplt 'delay' clocks later with 'res_val', then
    // runs to the next strt_cnv and checks the spacing between the two.
    task automatic applyStimulus(input logic [2:0] ch, input int delay,
                                 input bit respond, input logic [11:0] res_val,
                                 input int period);
        int cyc;
        checkOutput("chnnl", 32'(chnnl), 32'(ch));
        cyc = 0;
        if (respond) begin
            repeat (delay) begin
                @(posedge clk);
                cyc++;
            end
            #1;
            cnv_cmplt = 1'b1;
            res       = res_val;
            @(posedge clk);
            cyc++;
            #1;
            cnv_cmplt = 1'b0;
            res       = 12'h000;
        end
        waitStrt(cyc);
        checkOutput("strt_period", 32'(cyc), 32'(period));
    endtask

    task automatic checkPots(input string tag, input logic [11:0] lp,
                             input logic [11:0] b1, input logic [11:0] b2,
                             input logic [11:0] b3, input logic [11:0] hp,
                             input logic [11:0] vol);
        checkOutput({tag, "_POT_LP"}, 32'(POT_LP), 32'(lp));
        checkOutput({tag, "_POT_B1"}, 32'(POT_B1), 32'(b1));
        checkOutput({tag, "_POT_B2"}, 32'(POT_B2), 32'(b2));
        checkOutput({tag, "_POT_B3"}, 32'(POT_B3), 32'(b3));
        checkOutput({tag, "_POT_HP"}, 32'(POT_HP), 32'(hp));
        checkOutput({tag, "_VOLUME"}, 32'(VOLUME), 32'(vol));
    endtask

    initial begin
        int cyc;
        test_count = 0;
        fail_count = 0;
        rst_n      = 1'b0;
        cnv_cmplt  = 1'b0;
        res        = 12'h000;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkPots("rst", 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
        checkOutput("rst_chnnl", 32'(chnnl), 32'd1);
        checkOutput("rst_strt", 32'(strt_cnv), 32'd0);
        checkOutput("rst_sweep", 32'(sweep_done), 32'd0);
        checkOutput("rst_tmo", 32'(tmo_err), 32'd0);

        // Release mid-cycle: clock 1 is IDLE, strt_cnv is high in clock 2.
        rst_n = 1'b1;
        #1;
        checkOutput("clk1_strt", 32'(strt_cnv), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("clk2_strt", 32'(strt_cnv), 32'd1);

        // Sweep 1: every slot answers after 50 clocks with 0x100 + channel.
        for (int s = 0; s < 6; s++) begin
            applyStimulus(exp_ch[s], 50, 1'b1, 12'h100 + 12'(exp_ch[s]), PERIOD_NORM);
        end
        checkPots("sweep1", 12'h101, 12'h100, 12'h104, 12'h102, 12'h103, 12'h107);
        checkOutput("sweep1_count", 32'(sweep_count), 32'd1);
        checkOutput("sweep1_tmo", 32'(tmo_err), 32'd0);

        // Sweep 2: slot 1 completes on the very clock the timeout expires,
        // slot 2 preloads POT_B2 with 0xABC.
        applyStimulus(exp_ch[0], 50, 1'b1, 12'h101, PERIOD_NORM);
        applyStimulus(exp_ch[1], 4096, 1'b1, 12'h555, PERIOD_TMO);
        checkOutput("edge_POT_B1", 32'(POT_B1), 32'h555);
        checkOutput("edge_tmo", 32'(tmo_err), 32'd0);
        applyStimulus(exp_ch[2], 50, 1'b1, 12'hABC, PERIOD_NORM);
        checkOutput("preload_POT_B2", 32'(POT_B2), 32'hABC);
        for (int s = 3; s < 6; s++) begin
            applyStimulus(exp_ch[s], 50, 1'b1, 12'h100 + 12'(exp_ch[s]), PERIOD_NORM);
        end
        checkOutput("sweep2_count", 32'(sweep_count), 32'd2);

        // Sweep 3: slot 2 never answers and times out.
        applyStimulus(exp_ch[0], 50, 1'b1, 12'h101, PERIOD_NORM);
        applyStimulus(exp_ch[1], 50, 1'b1, 12'h100, PERIOD_NORM);
        applyStimulus(exp_ch[2], 0, 1'b0, 12'h000, PERIOD_TMO);
        checkOutput("tmo_set", 32'(tmo_err), 32'd1);
        checkOutput("tmo_POT_B2", 32'(POT_B2), 32'hABC);
        applyStimulus(exp_ch[3], 50, 1'b1, 12'h102, PERIOD_NORM);
        checkOutput("tmo_sticky", 32'(tmo_err), 32'd1);

        // Slot 4: normal answer, then a stray cnv_cmplt inside GAP.
        checkOutput("slot4_chnnl", 32'(chnnl), 32'd3);
        repeat (50) @(posedge clk);
        #1;
        cnv_cmplt = 1'b1;
        res       = 12'h333;
        @(posedge clk);
        #1;
        cnv_cmplt = 1'b0;
        checkOutput("slot4_POT_HP", 32'(POT_HP), 32'h333);
        repeat (100) @(posedge clk);
        #1;
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
        @(posedge clk);
        #1;
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        checkPots("gap_ignore", 12'h101, 12'h100, 12'hABC, 12'h102, 12'h333, 12'h107);

        // Slot 5 starts; reset lands in the middle of its WAIT.
        cyc = 0;
        waitStrt(cyc);
        checkOutput("slot5_chnnl", 32'(chnnl), 32'd7);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkPots("async_rst", 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
        checkOutput("async_rst_chnnl", 32'(chnnl), 32'd1);
        checkOutput("async_rst_tmo", 32'(tmo_err), 32'd0);
        checkOutput("async_rst_strt", 32'(strt_cnv), 32'd0);

        // Late cnv_cmplt held through IDLE and START after release is ignored.
        @(negedge clk);
        rst_n     = 1'b1;
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
        @(posedge clk);
        #1;
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        checkOutput("restart_strt", 32'(strt_cnv), 32'd1);
        checkOutput("late_POT_LP", 32'(POT_LP), 32'h000);
        checkOutput("late_VOLUME", 32'(VOLUME), 32'h000);

        // Sequence restarts at slot 0 on channel 1.
        applyStimulus(exp_ch[0], 50, 1'b1, 12'h101, PERIOD_NORM);
        checkOutput("restart_POT_LP", 32'(POT_LP), 32'h101);
        checkOutput("restart_chnnl1", 32'(chnnl), 32'd0);
        checkOutput("final_sweeps", 32'(sweep_count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
